soundgen_note_player: RTL and testbench

- Playback engine that consumes tone settings: a small writable pattern store holds (period, duration) note entries.
- On start, it reads the entries in order and drives a square-wave tone for each note.
- It sits between the control/config interface (writer) and the audio output pin of tt_um_soundgen.
- It is the reader of the note pattern and the consumer of the counter-based timing used elsewhere in the design.

---
 rtl/soundgen_note_player_if.sv | 30 +++
 rtl/soundgen_note_player.sv | 142 ++++++++++++++
 tb/tb_soundgen_note_player.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/soundgen_note_player_if.sv
// Pattern-write, playback-control and audio-status bundle for the note player.
// The master (controller) drives writes and commands; the slave (player) returns audio and status.
interface soundgen_note_player_if #(
  parameter int DIV_BW  = 8,
  parameter int DUR_BW  = 4,
  parameter int ADDR_BW = 3
);
  logic               wr_en;
  logic [ADDR_BW-1:0] wr_addr;
  logic [DIV_BW-1:0]  wr_period;
  logic [DUR_BW-1:0]  wr_dur;
  logic [ADDR_BW:0]   len;
  logic               loop;
  logic               start;
  logic               stop;
  logic               tone;
  logic               busy;
  logic [ADDR_BW-1:0] note_idx;
  logic               done;

  modport master (
    output wr_en, wr_addr, wr_period, wr_dur, len, loop, start, stop,
    input  tone, busy, note_idx, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_period, wr_dur, len, loop, start, stop,
    output tone, busy, note_idx, done
  );
endinterface

// File: rtl/soundgen_note_player.sv
// Note pattern player: plays (half-period, duration) entries from a small writable store
// as a square wave, one FETCH cycle per note followed by dur*TICK PLAY cycles.
module soundgen_note_player #(
  parameter int DIV_BW  = 8,
  parameter int DUR_BW  = 4,
  parameter int ADDR_BW = 3,
  parameter int TICK    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  soundgen_note_player_if.slave bus
);
  localparam int DEPTH   = 2 ** ADDR_BW;
  localparam int TICK_BW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [TICK_BW-1:0] TICK_LAST = TICK_BW'(TICK - 1);
  localparam logic [ADDR_BW:0]   LEN_MAX   = (ADDR_BW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

  state_t             state;
  logic [DIV_BW-1:0]  period_mem [DEPTH];
  logic [DUR_BW-1:0]  dur_mem    [DEPTH];
  logic [ADDR_BW:0]   len_q;
  logic [ADDR_BW-1:0] idx;
  logic [DIV_BW-1:0]  period_q;
  logic [DUR_BW-1:0]  dur_q;
  logic [DIV_BW-1:0]  div_cnt;
  logic [TICK_BW-1:0] tick_cnt;
  logic [DUR_BW-1:0]  dur_cnt;
  logic               tone_q;
  logic               busy_q;
  logic               done_q;
  logic               last_cycle;
  logic               idx_last;

  function automatic logic [ADDR_BW:0] clamp_len(input logic [ADDR_BW:0] l);
    return (l > LEN_MAX) ? LEN_MAX : l;
  endfunction

  function automatic logic [DUR_BW-1:0] dur_floor(input logic [DUR_BW-1:0] d);
    return (d == '0) ? DUR_BW'(1) : d;
  endfunction

  assign last_cycle = (tick_cnt == TICK_LAST) && (dur_cnt == dur_q - DUR_BW'(1));
  assign idx_last   = ({1'b0, idx} == len_q - (ADDR_BW + 1)'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      len_q    <= '0;
      idx      <= '0;
      period_q <= '0;
      dur_q    <= '0;
      div_cnt  <= '0;
      tick_cnt <= '0;
      dur_cnt  <= '0;
      tone_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        period_mem[i] <= '0;
        dur_mem[i]    <= '0;
      end
    end else begin
      done_q <= 1'b0;
      // The store is written regardless of state; a note already fetched is unaffected.
      if (bus.wr_en) begin
        period_mem[bus.wr_addr] <= bus.wr_period;
        dur_mem[bus.wr_addr]    <= bus.wr_dur;
      end
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop && (bus.len != '0)) begin
            len_q  <= clamp_len(bus.len);
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= FETCH;
          end
        end
        FETCH: begin
          if (bus.stop) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            tone_q <= 1'b0;
            idx    <= '0;
          end else begin
            period_q <= period_mem[idx];
            dur_q    <= dur_floor(dur_mem[idx]);
            div_cnt  <= '0;
            tick_cnt <= '0;
            dur_cnt  <= '0;
            tone_q   <= 1'b0;
            state    <= PLAY;
          end
        end
        PLAY: begin
          if (bus.stop) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            tone_q <= 1'b0;
            idx    <= '0;
          end else if (last_cycle) begin
            tone_q <= 1'b0;
            if (!idx_last) begin
              idx   <= idx + ADDR_BW'(1);
              state <= FETCH;
            end else if (bus.loop) begin
              idx   <= '0;
              state <= FETCH;
            end else begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end else begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              dur_cnt  <= dur_cnt + DUR_BW'(1);
            end else begin
              tick_cnt <= tick_cnt + TICK_BW'(1);
            end
            // A zero half-period is a rest: divider and tone stay idle.
            if (period_q != '0) begin
              if (div_cnt == period_q - DIV_BW'(1)) begin
                div_cnt <= '0;
                tone_q  <= ~tone_q;
              end else begin
                div_cnt <= div_cnt + DIV_BW'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tone     = tone_q;
  assign bus.busy     = busy_q;
  assign bus.note_idx = idx;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_soundgen_note_player.sv
// Bench for soundgen_note_player: directed scenarios plus randomized patterns, each cycle
// compared against a note-level model that derives the tone from elapsed play time.
module tb_soundgen_note_player;
  localparam int DIV_BW  = 8;
  localparam int DUR_BW  = 4;
  localparam int ADDR_BW = 3;
  localparam int TICK    = 4;
  localparam int DEPTH   = 2 ** ADDR_BW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  soundgen_note_player_if #(.DIV_BW(DIV_BW), .DUR_BW(DUR_BW), .ADDR_BW(ADDR_BW)) bus ();

  soundgen_note_player #(.DIV_BW(DIV_BW), .DUR_BW(DUR_BW), .ADDR_BW(ADDR_BW), .TICK(TICK)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: playback described as "which note, how many cycles into it".
  int mem_per [DEPTH];
  int mem_dur [DEPTH];
  bit m_busy, m_fetch, m_tone, m_done;
  int m_idx, m_len, m_k, m_per, m_dur;

  task automatic model_edge();
    m_done = 1'b0;
    if (rst) begin
      m_busy = 0; m_fetch = 0; m_tone = 0; m_idx = 0; m_len = 0; m_k = 0; m_per = 0; m_dur = 0;
      for (int i = 0; i < DEPTH; i++) begin mem_per[i] = 0; mem_dur[i] = 0; end
      return;
    end
    if (!m_busy) begin
      if (bus.start && !bus.stop && bus.len != 0) begin
        m_len = (int'(bus.len) > DEPTH) ? DEPTH : int'(bus.len);
        m_idx = 0; m_busy = 1; m_fetch = 1;
      end
    end else if (bus.stop) begin
      m_busy = 0; m_fetch = 0; m_idx = 0; m_tone = 0;
    end else if (m_fetch) begin
      m_per = mem_per[m_idx];
      m_dur = (mem_dur[m_idx] == 0) ? 1 : mem_dur[m_idx];
      m_k = 0; m_fetch = 0; m_tone = 0;
    end else begin
      m_k++;
      if (m_k == m_dur * TICK) begin
        m_tone = 0;
        if (m_idx < m_len - 1) begin m_idx++; m_fetch = 1; end
        else if (bus.loop) begin m_idx = 0; m_fetch = 1; end
        else begin m_busy = 0; m_done = 1; end
      end else begin
        // Number of completed half-periods decides the level.
        m_tone = (m_per != 0) && (((m_k / m_per) % 2) == 1);
      end
    end
    if (bus.wr_en) begin
      mem_per[bus.wr_addr] = int'(bus.wr_period);
      mem_dur[bus.wr_addr] = int'(bus.wr_dur);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      if (bus.done === 1'b1) done_seen++;
      check("tone", 32'(bus.tone), 32'(m_tone));
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("note_idx", 32'(bus.note_idx), 32'(m_idx));
      check("done", 32'(bus.done), 32'(m_done));
    end
  endtask

  task automatic write_entry(input int a, input int p, input int d);
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_BW'(a); bus.wr_period = DIV_BW'(p); bus.wr_dur = DUR_BW'(d);
    step(1);
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_start(input int l, input bit lp);
    bus.len = (ADDR_BW + 1)'(l); bus.loop = lp; bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_period = '0; bus.wr_dur = '0;
    bus.len = '0; bus.loop = 0; bus.start = 0; bus.stop = 0;

    // Reset, then idle quiet period
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(20);

    // Single note: period 3, dur 2 -> rises after PLAY cycle 3, falls after 6
    write_entry(0, 3, 2);
    done_seen = 0;
    pulse_start(1, 0);
    step(4);
    check("single_rise", 32'(bus.tone), 32'd1);
    step(8);
    check("single_done_count", 32'(done_seen), 32'd1);

    // Three notes: tone, rest, fastest tone
    write_entry(0, 2, 1);
    write_entry(1, 0, 1);
    write_entry(2, 1, 1);
    done_seen = 0;
    pulse_start(3, 0);
    step(5);
    check("seq_idx1", 32'(bus.note_idx), 32'd1);
    step(14);
    check("seq_done_count", 32'(done_seen), 32'd1);

    // Looping two entries, then stop mid-note
    done_seen = 0;
    pulse_start(2, 1);
    step(23);
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    check("stop_busy", 32'(bus.busy), 32'd0);
    step(3);
    check("loop_no_done", 32'(done_seen), 32'd0);

    // Overwrite entry 0 period while it plays in a loop
    write_entry(0, 3, 2);
    pulse_start(1, 1);
    step(4);
    write_entry(0, 5, 2);
    step(25);
    bus.stop = 1'b1; step(1); bus.stop = 1'b0;

    // start with stop in IDLE, and start with len 0: both ignored
    bus.stop = 1'b1;
    pulse_start(2, 0);
    bus.stop = 1'b0;
    check("start_stop_idle", 32'(bus.busy), 32'd0);
    pulse_start(0, 0);
    check("len0_idle", 32'(bus.busy), 32'd0);
    step(2);

    // len 15 clamps to 8 entries
    for (int i = 0; i < DEPTH; i++) write_entry(i, 1, 1);
    done_seen = 0;
    pulse_start(15, 0);
    step(8 * 5 + 2);
    check("clamp_done_count", 32'(done_seen), 32'd1);

    // zero duration behaves as one tick
    write_entry(0, 2, 0);
    pulse_start(1, 0);
    step(6);

    // reset during PLAY
    write_entry(0, 4, 7);
    pulse_start(1, 0);
    step(6);
    rst = 1'b1;
    step(1);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    step(3);

    // Randomized patterns with occasional writes, stops and loop changes
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++)
        write_entry(i, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
      pulse_start(int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 120; c++) begin
        bus.wr_en = ($urandom_range(0, 9) == 0);
        bus.wr_addr = ADDR_BW'($urandom);
        bus.wr_period = DIV_BW'($urandom_range(0, 6));
        bus.wr_dur = DUR_BW'($urandom_range(0, 3));
        bus.stop = ($urandom_range(0, 59) == 0);
        bus.start = ($urandom_range(0, 19) == 0);
        bus.len = (ADDR_BW + 1)'($urandom_range(0, 10));
        if ($urandom_range(0, 29) == 0) bus.loop = ~bus.loop;
        step(1);
      end
      bus.wr_en = 0; bus.start = 0;
      bus.stop = 1'b1; step(1); bus.stop = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
